// File: rtl/piso_sr_tx.sv
// Parallel-in serial-out transmitter: frames a WIDTH-bit word as start bit,
// MSB-first data, optional parity and stop bit, each held BAUD_DIV clocks.
module piso_sr_tx #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned BAUD_DIV   = 1,
  parameter int unsigned PARITY_EN  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic [WIDTH-1:0] pi,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int unsigned   BW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned   CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t           state_q, state_d;
  logic [BW-1:0]    baud_q, baud_d;
  logic [CW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             par_q, par_d;
  logic             sout_q, sout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             in_ready_q, in_ready_d;

  logic accept;
  logic last_baud;

  assign accept    = in_valid & in_ready_q;
  assign last_baud = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          baud_d  = '0;
          shreg_d = pi;
          par_d   = (^pi) ^ (PARITY_ODD != 0);
        end
      end
      START: begin
        if (last_baud) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (last_baud) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_d   = bit_q + 1'b1;
            shreg_d = shreg_q << 1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      PARITY: begin
        if (last_baud) begin
          state_d = STOP;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (last_baud) begin
          baud_d = '0;
          if (accept) begin
            state_d = START;
            shreg_d = pi;
            par_d   = (^pi) ^ (PARITY_ODD != 0);
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every output comes straight off a flop.
  always_comb begin
    sout_d = 1'b1;
    case (state_d)
      START:   sout_d = 1'b0;
      DATA:    sout_d = shreg_d[WIDTH-1];
      PARITY:  sout_d = par_d;
      default: sout_d = 1'b1;
    endcase
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == STOP) && (baud_d == BAUD_LAST);
    in_ready_d = (state_d == IDLE) || done_d;
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      sout_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      sout_q     <= sout_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready = in_ready_q;
  assign sout     = sout_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_piso_sr_tx.sv
// Scoreboard bench for piso_sr_tx: three parameterisations, expected per-clock
// {sout,busy,done,in_ready} pushed at acceptance and checked by a negedge monitor.
module tb_piso_sr_tx;

  logic       clk     = 1'b0;
  logic       clear_n = 1'b0;
  logic [3:0] pi      = '0;
  logic       vld     = 1'b0;
  logic [1:0] sel     = 2'd0;
  logic [2:0] vld_i;
  logic [2:0] rdy, sout, busy, done;

  logic [3:0] expq[$];
  logic [3:0] mon_exp;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign vld_i = vld ? (3'b001 << sel) : 3'b000;

  piso_sr_tx #(.WIDTH(4), .BAUD_DIV(2), .PARITY_EN(1), .PARITY_ODD(0)) u_even (
    .clk(clk), .clear_n(clear_n), .pi(pi), .in_valid(vld_i[0]),
    .in_ready(rdy[0]), .sout(sout[0]), .busy(busy[0]), .done(done[0])
  );

  piso_sr_tx #(.WIDTH(4), .BAUD_DIV(1), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
    .clk(clk), .clear_n(clear_n), .pi(pi), .in_valid(vld_i[1]),
    .in_ready(rdy[1]), .sout(sout[1]), .busy(busy[1]), .done(done[1])
  );

  piso_sr_tx #(.WIDTH(4), .BAUD_DIV(1), .PARITY_EN(0), .PARITY_ODD(0)) u_nopar (
    .clk(clk), .clear_n(clear_n), .pi(pi), .in_valid(vld_i[2]),
    .in_ready(rdy[2]), .sout(sout[2]), .busy(busy[2]), .done(done[2])
  );

  function automatic void chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: sout/busy/done/rdy got %b, expected %b at %0t", name, got, exp, $time);
    end
  endfunction

  // Idle is {1,0,0,1}; held in reset is {1,0,0,0}.
  always @(negedge clk) begin
    if (!clear_n) mon_exp = 4'b1000;
    else if (expq.size() != 0) mon_exp = expq.pop_front();
    else mon_exp = 4'b1001;
    chk("frame", {sout[sel], busy[sel], done[sel], rdy[sel]}, mon_exp);
    for (int i = 0; i < 3; i++) begin
      if (2'(i) != sel) chk("other_quiet", {sout[i], busy[i], done[i], 1'b0}, 4'b1000);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [6:0] bits, input int nb, input int baud);
    for (int b = nb - 1; b >= 0; b--) begin
      for (int c = 0; c < baud; c++) begin
        expq.push_back({bits[b], 1'b1, (b == 0 && c == baud - 1), (b == 0 && c == baud - 1)});
      end
    end
  endtask

  task automatic send(input logic [1:0] s, input logic [3:0] w, input logic [6:0] bits,
                      input int nb, input bit hold);
    int n = 0;
    sel = s;
    vld = 1'b1;
    while (!rdy[sel] && n < 200) begin
      tick();
      n++;
    end
    if (!rdy[sel]) begin
      chk("accept_timeout", {3'b000, rdy[sel]}, 4'b0001);
      vld = 1'b0;
      return;
    end
    pi = w;
    @(posedge clk);
    push_frame(bits, nb, (s == 2'd0) ? 2 : 1);
    #1;
    if (!hold) vld = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((expq.size() != 0 || busy[sel]) && n < 400) begin
      tick();
      n++;
    end
    if (expq.size() != 0 || busy[sel]) chk("idle_timeout", {3'b000, busy[sel]}, 4'b0000);
    repeat (3) tick();
  endtask

  initial begin
    // reset and idle
    tick();
    tick();
    clear_n = 1'b1;
    expq.push_back(4'b1000);
    repeat (4) tick();

    // even parity, BAUD_DIV=2
    send(2'd0, 4'b1001, 7'b0100101, 7, 1'b0);
    wait_idle();

    // odd parity and no parity, BAUD_DIV=1
    send(2'd1, 4'b1011, 7'b0101101, 7, 1'b0);
    wait_idle();
    send(2'd1, 4'b0000, 7'b0000011, 7, 1'b0);
    wait_idle();
    send(2'd2, 4'b1110, 7'b0011101, 6, 1'b0);
    wait_idle();

    // back-to-back with in_valid held; second word appears on STOP's last cycle
    send(2'd0, 4'b1010, 7'b0101001, 7, 1'b1);
    send(2'd0, 4'b1111, 7'b0111101, 7, 1'b0);
    wait_idle();
    send(2'd2, 4'b1000, 7'b0010001, 6, 1'b1);
    send(2'd2, 4'b0111, 7'b0001111, 6, 1'b0);
    wait_idle();

    // in_valid pulse while busy is ignored
    send(2'd0, 4'b1100, 7'b0110001, 7, 1'b0);
    repeat (5) tick();
    pi  = 4'b0000;
    vld = 1'b1;
    tick();
    vld = 1'b0;
    wait_idle();

    // reset mid-frame while sout is low, then a clean frame
    send(2'd0, 4'b1001, 7'b0100101, 7, 1'b0);
    repeat (4) tick();
    clear_n = 1'b0;
    expq.delete();
    #1;
    chk("async_reset", {sout[0], busy[0], done[0], rdy[0]}, 4'b1000);
    repeat (2) tick();
    clear_n = 1'b1;
    expq.push_back(4'b1000);
    send(2'd0, 4'b0110, 7'b0011001, 7, 1'b0);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1);
  end

endmodule

// File: doc/piso_sr_tx.md
Name: piso_sr_tx

Overview:
Parallel-in serial-out transmitter. It is the sending end of the serial link whose receiving end rebuilds the parallel word.
- Accepts a WIDTH-bit word over a valid/ready handshake.
- Sends it on a single line as a frame: start bit, data bits MSB first, optional parity bit, stop bit.
- Each bit is held for BAUD_DIV clocks.
- Sits between the parallel datapath and the serial pin.

Parameters:
WIDTH, 4, data word width in bits (>=1).
BAUD_DIV, 1, clock cycles each serial bit is held (>=1).
PARITY_EN, 1, 1 = insert parity bit after the data bits, 0 = no parity bit.
PARITY_ODD, 0, 0 = even parity (parity bit = XOR of data), 1 = odd parity (inverted XOR); ignored when PARITY_EN=0.

Ports:
clk  input  1  system clock, rising-edge active.
clear_n  input  1  asynchronous active-low reset.
pi  input  WIDTH  parallel word to transmit.
in_valid  input  1  pi holds a word to send.
in_ready  output  1  transmitter can accept a word this cycle.
sout  output  1  serial line, idles high.
busy  output  1  a frame is in progress.
done  output  1  one-cycle pulse on the final clock of a frame's stop bit.

Behaviour:
- Reset (clear_n=0, asynchronous):
  - State = IDLE; sout=1, busy=0, done=0, in_ready=0 while asserted.
  - Bit counter, baud counter and shift register = 0.
  - A reset asserted mid-frame aborts the frame immediately; sout returns high with no clock needed.
- After clear_n deasserts: in_ready=1 in IDLE from the next cycle.
- Handshake:
  - A word is accepted at a rising edge when in_valid=1 and in_ready=1.
  - pi is captured into the shift register at that edge; parity is computed from the captured value.
  - in_valid while in_ready=0 is ignored; no queuing.
  - pi may change freely after acceptance.
- State machine, all outputs registered:
  - IDLE: sout=1, busy=0. On accept -> START.
  - START: sout=0 for BAUD_DIV cycles -> DATA.
  - DATA: sout = shift register MSB, held BAUD_DIV cycles per bit. Register shifts left one bit per bit period. After WIDTH bits -> PARITY if PARITY_EN, else STOP.
  - PARITY: sout = parity bit for BAUD_DIV cycles -> STOP.
  - STOP: sout=1 for BAUD_DIV cycles. On the last cycle: done=1 and in_ready=1. Then -> IDLE, or -> START if a word is accepted on that same edge (back-to-back, no idle gap).
- Latency: sout falls on the first clock after the accepting edge.
- Frame length: (2 + WIDTH + PARITY_EN) * BAUD_DIV clocks.
- busy=1 from the cycle after acceptance through the last STOP cycle, inclusive.
  - Stays 1 across back-to-back frames.
  - Deasserts only when returning to IDLE.
- Baud counter runs 0..BAUD_DIV-1 and wraps; bit counter runs 0..WIDTH-1.
  - BAUD_DIV=1: every state advances each clock.
- Simultaneous events: reset wins over accept and over any state transition.
- Only one frame is in flight at a time; the word is never corrupted by pi changes mid-frame.

Test Plan:
1. Reset and idle: clear_n=0 for 10 ns, then 1, with in_valid=0 -> sout=1, busy=0, done=0, in_ready=1 on every cycle.
2. Even-parity frame: WIDTH=4, BAUD_DIV=2, PARITY_EN=1, PARITY_ODD=0; send pi=4'b1001 -> sout per bit 0,1,0,0,1,0,1, each held 2 clocks (14 clocks). done pulses once on clock 14; busy high for exactly 14 clocks.
3. Odd parity, and parity disabled, BAUD_DIV=1:
   - PARITY_ODD=1, pi=4'b1011 -> sout 0,1,0,1,1,0,1 (parity 0, since three ones).
   - PARITY_EN=0, pi=4'b1110 -> 0,1,1,1,0,1 (6 clocks).
4. Back-to-back: hold in_valid=1 with pi=4'b1010, then 4'b1111 at STOP's last cycle -> second START immediately follows first STOP; no idle cycle; busy never drops; done pulses twice.
5. Ignore while busy: mid-frame, pulse in_valid with pi=4'b0000 -> no effect; the frame for the original word completes unchanged, and no extra frame follows.
6. Reset mid-frame: assert clear_n=0 during DATA of pi=4'b1001 -> sout=1, busy=0 asynchronously. After release, a new word 4'b0110 transmits a correct full frame.
